// File: rtl/keccak_f800_sched_pkg.sv
// keccak_f800_sched_pkg: keccak-f[800] types, constants, round function and scheduler FSM states
package keccak_f800_sched_pkg;
    localparam int KECCAK_ROUNDS = 22;
    typedef logic [24:0][31:0] keccak_state;
    typedef enum logic [1:0] {IDLE, RUN, DONE} sched_state_t;
    localparam int keccakf_rotc [24] = '{1, 3, 6, 10, 15, 21, 28, 36, 45, 55, 2, 14,
                                         27, 41, 56, 8, 25, 43, 62, 18, 39, 61, 20, 44};
    localparam int keccakf_piln [24] = '{10, 7, 11, 17, 18, 3, 5, 16, 8, 21, 24, 4,
                                         15, 23, 19, 13, 12, 2, 20, 14, 22, 9, 6, 1};
    localparam logic [31:0] keccakf_rndc [22] = '{
        32'h00000001, 32'h00008082, 32'h0000808a, 32'h80008000, 32'h0000808b, 32'h80000001,
        32'h80008081, 32'h00008009, 32'h0000008a, 32'h00000088, 32'h80008009, 32'h8000000a,
        32'h8000808b, 32'h0000008b, 32'h00008089, 32'h00008003, 32'h00008002, 32'h00000080,
        32'h0000800a, 32'h8000000a, 32'h80008081, 32'h00008080};
    function automatic logic [31:0] rotl32(input logic [31:0] x, input int n);
        int s;
        s = n % 32;
        return s == 0 ? x : (x << s) | (x >> (32 - s));
    endfunction
    function automatic keccak_state keccak_f800_round(input keccak_state s_in, input logic [4:0] r);
        keccak_state s;
        logic [4:0][31:0] bc;
        logic [31:0] t, b0;
        s = s_in;
        for (int i = 0; i < 5; i++) bc[i] = s[i] ^ s[i+5] ^ s[i+10] ^ s[i+15] ^ s[i+20];
        for (int i = 0; i < 5; i++) begin
            t = bc[(i+4)%5] ^ rotl32(bc[(i+1)%5], 1);
            for (int j = 0; j < 25; j += 5) s[j+i] ^= t;
        end
        t = s[1];
        for (int i = 0; i < 24; i++) begin
            b0 = s[keccakf_piln[i]];
            s[keccakf_piln[i]] = rotl32(t, keccakf_rotc[i]);
            t = b0;
        end
        for (int j = 0; j < 25; j += 5) begin
            for (int i = 0; i < 5; i++) bc[i] = s[j+i];
            for (int i = 0; i < 5; i++) s[j+i] ^= ~bc[(i+1)%5] & bc[(i+2)%5];
        end
        s[0] ^= keccakf_rndc[r];
        return s;
    endfunction
endpackage

// File: rtl/keccak_f800_sched_if.sv
// keccak_f800_sched_if: requester and response bus of the shared keccak-f[800] engine
interface keccak_f800_sched_if #(
    parameter int NUM_REQ = 2,
    parameter int ID_W = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1
);
    logic [NUM_REQ-1:0] req_valid, req_ready;
    logic [NUM_REQ*256-1:0] req_header, req_digest;
    logic [NUM_REQ*64-1:0] req_nonce;
    logic resp_valid, resp_ready, busy;
    logic [ID_W-1:0] resp_id;
    logic [255:0] resp_data;
    modport master(output req_valid, req_header, req_nonce, req_digest, resp_ready,
                   input req_ready, resp_valid, resp_id, resp_data, busy);
    modport slave(input req_valid, req_header, req_nonce, req_digest, resp_ready,
                  output req_ready, resp_valid, resp_id, resp_data, busy);
endinterface

// File: rtl/keccak_f800_sched_arb.sv
// keccak_f800_rr_arb: one-hot grant of the first valid requester strictly after ptr, wrapping
module keccak_f800_rr_arb #(
    parameter int NUM_REQ = 2,
    parameter int ID_W = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    idx
);
    logic [ID_W-1:0] c;
    always_comb begin
        grant = '0;
        idx = '0;
        c = '0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            c = ID_W'((int'(ptr) + i) % NUM_REQ);
            grant = valid[c] ? NUM_REQ'(1) << c : grant;
            idx = valid[c] ? c : idx;
        end
    end
endmodule

// File: rtl/keccak_f800_sched.sv
// keccak_f800_sched: round-robin shared iterative keccak-f[800] engine (absorb 18 words, 22 rounds, squeeze 8)
module keccak_f800_sched
    import keccak_f800_sched_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ROUNDS_PER_CYCLE = 1,
    parameter int ID_W = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1
) (
    input logic clk,
    input logic reset,
    keccak_f800_sched_if.slave bus
);
    localparam logic [4:0] RPC = 5'(ROUNDS_PER_CYCLE);
    sched_state_t fsm;
    logic [4:0] round;
    logic [ID_W-1:0] rr_ptr, win;
    logic [NUM_REQ-1:0] grant;
    keccak_state st, load;
    keccak_state chain [ROUNDS_PER_CYCLE+1];

    keccak_f800_rr_arb #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arb (
        .valid(bus.req_valid),
        .ptr(rr_ptr),
        .grant(grant),
        .idx(win)
    );

    assign bus.req_ready = fsm == IDLE ? grant : '0;
    assign load = {224'd0, bus.req_digest[win*256 +: 256], bus.req_nonce[win*64 +: 64],
                   bus.req_header[win*256 +: 256]};
    assign chain[0] = st;

    for (genvar g = 0; g < ROUNDS_PER_CYCLE; g++) begin : g_rnd
        logic [4:0] ri;
        assign ri = round + 5'(g);
        assign chain[g+1] = keccak_f800_round(chain[g], ri < 5'(KECCAK_ROUNDS) ? ri : 5'd0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fsm <= IDLE;
            round <= '0;
            rr_ptr <= ID_W'(NUM_REQ - 1);
            st <= '0;
            bus.resp_valid <= 1'b0;
            bus.resp_id <= '0;
            bus.resp_data <= '0;
            bus.busy <= 1'b0;
        end else begin
            case (fsm)
                IDLE: if (|grant) begin
                    st <= load;
                    bus.resp_id <= win;
                    rr_ptr <= win;
                    round <= '0;
                    bus.busy <= 1'b1;
                    fsm <= RUN;
                end
                RUN: begin
                    st <= chain[ROUNDS_PER_CYCLE];
                    round <= round + RPC;
                    if (round + RPC == 5'(KECCAK_ROUNDS)) begin
                        bus.resp_data <= chain[ROUNDS_PER_CYCLE][7:0];
                        bus.resp_valid <= 1'b1;
                        fsm <= DONE;
                    end
                end
                DONE: if (bus.resp_ready) begin
                    bus.resp_valid <= 1'b0;
                    bus.busy <= 1'b0;
                    fsm <= IDLE;
                end
                default: fsm <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_keccak_f800_sched.sv
// tb_keccak_f800_sched: table-driven and randomized checks against a lane-coordinate keccak-f[800] model
module tb_keccak_f800_sched;
    parameter int RPC = 1;
    localparam int N = 2;
    localparam int IDW = 1;
    localparam int LAT = 22 / RPC;
    localparam int MID = LAT > 7 ? 7 : LAT - 1;

    typedef struct {
        int req;
        logic [255:0] hdr;
        logic [63:0] non;
        logic [255:0] dig;
        int hold;
        logic [255:0] exp;
    } vec_t;

    logic clk = 0;
    logic reset = 1;
    always #5 clk = ~clk;

    keccak_f800_sched_if #(.NUM_REQ(N), .ID_W(IDW)) bus();
    keccak_f800_sched #(.NUM_REQ(N), .ROUNDS_PER_CYCLE(RPC), .ID_W(IDW)) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    logic [255:0] hdr_r [N];
    logic [255:0] dig_r [N];
    logic [63:0] non_r [N];
    logic [N-1:0] valids;
    logic rdy;
    int checks = 0;
    int errors = 0;
    int last = N - 1;

    always_comb begin
        for (int r = 0; r < N; r++) begin
            bus.req_header[r*256 +: 256] = hdr_r[r];
            bus.req_digest[r*256 +: 256] = dig_r[r];
            bus.req_nonce[r*64 +: 64] = non_r[r];
        end
        bus.req_valid = valids;
        bus.resp_ready = rdy;
    end

    function automatic logic [31:0] rot(input logic [31:0] x, input int n);
        return n == 0 ? x : (x << n) | (x >> (32 - n));
    endfunction

    function automatic logic rc_bit(input int t);
        logic [7:0] r;
        logic m;
        r = 8'h01;
        for (int i = 1; i <= t % 255; i++) begin
            m = r[7];
            r = r << 1;
            if (m) r ^= 8'h71;
        end
        return r[0];
    endfunction

    function automatic logic [255:0] ref_hash(input logic [255:0] h, input logic [63:0] n, input logic [255:0] d);
        logic [31:0] w [25];
        logic [31:0] a [5][5];
        logic [31:0] b [5][5];
        logic [31:0] c [5];
        logic [31:0] dd [5];
        logic [31:0] rc;
        int rho [5][5];
        int x, y, nx;
        logic [255:0] o;
        for (int i = 0; i < 25; i++) w[i] = 32'h0;
        for (int i = 0; i < 8; i++) begin
            w[i] = h[i*32 +: 32];
            w[10+i] = d[i*32 +: 32];
        end
        w[8] = n[31:0];
        w[9] = n[63:32];
        for (int i = 0; i < 5; i++) for (int j = 0; j < 5; j++) a[i][j] = w[i + 5*j];
        rho[0][0] = 0;
        x = 1;
        y = 0;
        for (int t = 0; t < 24; t++) begin
            rho[x][y] = ((t + 1) * (t + 2) / 2) % 32;
            nx = y;
            y = (2*x + 3*y) % 5;
            x = nx;
        end
        for (int rnd = 0; rnd < 22; rnd++) begin
            for (int i = 0; i < 5; i++) c[i] = a[i][0] ^ a[i][1] ^ a[i][2] ^ a[i][3] ^ a[i][4];
            for (int i = 0; i < 5; i++) dd[i] = c[(i+4)%5] ^ rot(c[(i+1)%5], 1);
            for (int i = 0; i < 5; i++) for (int j = 0; j < 5; j++) a[i][j] ^= dd[i];
            for (int i = 0; i < 5; i++) for (int j = 0; j < 5; j++) b[j][(2*i + 3*j) % 5] = rot(a[i][j], rho[i][j]);
            for (int i = 0; i < 5; i++) for (int j = 0; j < 5; j++) a[i][j] = b[i][j] ^ (~b[(i+1)%5][j] & b[(i+2)%5][j]);
            rc = 32'h0;
            for (int j = 0; j < 6; j++) if (rc_bit(j + 7*rnd)) rc |= 32'h1 << ((1 << j) - 1);
            a[0][0] ^= rc;
        end
        for (int i = 0; i < 8; i++) o[i*32 +: 32] = a[i%5][i/5];
        return o;
    endfunction

    function automatic logic [N-1:0] rr_expect(input logic [N-1:0] v, input int p);
        for (int i = 1; i <= N; i++) if (v[(p + i) % N]) return N'(1) << ((p + i) % N);
        return '0;
    endfunction

    function automatic logic [255:0] rnd256();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic chk(input string name, input logic [299:0] act, input logic [299:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic serve(input int hold, input bit drop, output int wid, output logic [IDW-1:0] gid,
                         output logic [255:0] data);
        int n;
        bit bad;
        logic [N-1:0] expg;
        wid = 0;
        n = 0;
        #1;
        while (bus.req_ready == '0 && n < 50) begin
            @(posedge clk);
            #2;
            n++;
        end
        expg = rr_expect(valids, last);
        chk("grant", 300'(bus.req_ready), 300'(expg));
        chk("busy_idle", 300'(bus.busy), 300'(0));
        for (int r = 0; r < N; r++) if (expg[r]) wid = r;
        @(posedge clk);
        #1;
        last = wid;
        if (drop) valids[wid] = 1'b0;
        n = 0;
        bad = 0;
        while (!bus.resp_valid && n < 100) begin
            if (bus.req_ready != '0 || !bus.busy) bad = 1;
            @(posedge clk);
            #1;
            n++;
        end
        chk("latency", 300'(n), 300'(LAT));
        chk("no_grant_in_run", 300'(bad), 300'(0));
        gid = bus.resp_id;
        data = bus.resp_data;
        chk("resp_id", 300'(gid), 300'(wid));
        for (int k = 0; k < hold; k++) begin
            @(posedge clk);
            #1;
            chk("done_hold", 300'({bus.resp_valid, bus.resp_id, bus.resp_data, bus.req_ready}),
                300'({1'b1, gid, data, {N{1'b0}}}));
        end
        rdy = 1;
        @(posedge clk);
        #1;
        rdy = 0;
        chk("resp_release", 300'({bus.resp_valid, bus.busy}), 300'(0));
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t tbl [6];
        int wid;
        logic [IDW-1:0] gid;
        logic [255:0] data;
        bit bad;
        valids = '0;
        rdy = 0;
        for (int r = 0; r < N; r++) begin
            hdr_r[r] = '0;
            dig_r[r] = '0;
            non_r[r] = '0;
        end
        tbl[0] = '{0, 256'h0, 64'h0, 256'h0, 0, 256'h0};
        tbl[1] = '{0, 256'h0, 64'h0123456789ABCDEF, {256{1'b1}}, 5, 256'h0};
        for (int i = 0; i < 8; i++) tbl[1].hdr[i*32 +: 32] = 32'(i + 1);
        tbl[2] = '{1, rnd256(), {$urandom, $urandom}, rnd256(), 0, 256'h0};
        tbl[3] = '{1, rnd256(), {$urandom, $urandom}, rnd256(), 2, 256'h0};
        tbl[4] = '{0, rnd256(), {$urandom, $urandom}, rnd256(), 1, 256'h0};
        tbl[5] = '{1, {256{1'b1}}, 64'hFFFFFFFF00000000, 256'h0, 0, 256'h0};
        for (int i = 0; i < 6; i++) tbl[i].exp = ref_hash(tbl[i].hdr, tbl[i].non, tbl[i].dig);

        repeat (3) @(posedge clk);
        #1;
        chk("reset_state", 300'({bus.req_ready, bus.busy, bus.resp_valid, bus.resp_id, bus.resp_data}), 300'(0));
        reset = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            chk("idle_quiet", 300'({bus.req_ready, bus.busy, bus.resp_valid, bus.resp_id, bus.resp_data}), 300'(0));
        end

        for (int i = 0; i < 6; i++) begin
            hdr_r[tbl[i].req] = tbl[i].hdr;
            non_r[tbl[i].req] = tbl[i].non;
            dig_r[tbl[i].req] = tbl[i].dig;
            valids = N'(1) << tbl[i].req;
            serve(tbl[i].hold, 1, wid, gid, data);
            chk("tbl_id", 300'(gid), 300'(tbl[i].req));
            chk("tbl_data", 300'(data), 300'(tbl[i].exp));
        end

        for (int r = 0; r < N; r++) begin
            hdr_r[r] = rnd256();
            non_r[r] = {$urandom, $urandom};
            dig_r[r] = rnd256();
        end
        valids = '1;
        for (int k = 0; k < 4; k++) begin
            serve(k == 1 ? 3 : 0, 0, wid, gid, data);
            chk("rr_data", 300'(data), 300'(ref_hash(hdr_r[wid], non_r[wid], dig_r[wid])));
        end
        valids = '0;

        hdr_r[0] = rnd256();
        valids = 2'b01;
        #1;
        chk("pre_reset_grant", 300'(bus.req_ready), 300'(rr_expect(valids, last)));
        @(posedge clk);
        #1;
        valids = '0;
        repeat (MID) @(posedge clk);
        #1;
        chk("mid_run", 300'({bus.busy, bus.resp_valid}), 300'(2'b10));
        reset = 1;
        @(posedge clk);
        #1;
        reset = 0;
        last = N - 1;
        chk("reset_mid_run", 300'({bus.req_ready, bus.busy, bus.resp_valid, bus.resp_id, bus.resp_data}), 300'(0));
        bad = 0;
        repeat (25) begin
            @(posedge clk);
            #1;
            if (bus.resp_valid || bus.busy) bad = 1;
        end
        chk("no_stale_resp", 300'(bad), 300'(0));
        valids = 2'b11;
        #1;
        chk("rr_ptr_after_reset", 300'(bus.req_ready), 300'(2'b01));
        valids = 2'b10;
        hdr_r[1] = rnd256();
        serve(0, 1, wid, gid, data);
        chk("post_reset_id", 300'(gid), 300'(1));
        chk("post_reset_data", 300'(data), 300'(ref_hash(hdr_r[1], non_r[1], dig_r[1])));

        for (int k = 0; k < 8; k++) begin
            for (int r = 0; r < N; r++) begin
                hdr_r[r] = rnd256();
                non_r[r] = {$urandom, $urandom};
                dig_r[r] = rnd256();
            end
            valids = N'($urandom_range(1, 3));
            serve($urandom_range(0, 3), 1'($urandom_range(0, 1)), wid, gid, data);
            chk("rand_data", 300'(data), 300'(ref_hash(hdr_r[wid], non_r[wid], dig_r[wid])));
        end
        valids = '0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/keccak_f800_sched.md
Name: keccak_f800_sched

Overview:
- Iterative keccak-f[800] engine shared by NUM_REQ requesters.
- A round-robin arbiter grants one requester at a time.
- The block absorbs 18 words into the state (8 header words, 64-bit nonce, 8 digest words) and executes 22 rounds at ROUNDS_PER_CYCLE per clock.
- It returns the 8-word squeeze with the winner's ID, and sits between the ProgPoW hash front-end lanes and the final-hash writeback.

Parameters:
- NUM_REQ, 2, number of requesters (1..8).
- ROUNDS_PER_CYCLE, 1, rounds applied per RUN cycle; legal values are 1, 2 and 11 (must divide 22).
- ID_W, $clog2(NUM_REQ) (min 1), width of resp_id.

Ports:
- clk  in  1  single clock; all flops on rising edge.
- reset  in  1  synchronous, active-high.
- req_valid  in  NUM_REQ  per-requester request valid; must be held until that requester's req_ready.
- req_ready  out  NUM_REQ  one-hot (or zero) grant/accept.
- req_header  in  NUM_REQ*8*32  header words 0..7 per requester.
- req_nonce  in  NUM_REQ*64  64-bit nonce per requester.
- req_digest  in  NUM_REQ*8*32  digest words 0..7 per requester.
- resp_valid  out  1  result available.
- resp_ready  in  1  consumer accepts the result.
- resp_id  out  ID_W  index of the requester that owns the result.
- resp_data  out  8*32  squeezed state words st[0..7].
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset values: FSM=IDLE, round counter=0, rr_ptr=NUM_REQ-1, state regs=0, resp_valid=0, resp_id=0, resp_data=0, busy=0, req_ready=0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - req_ready is the combinational round-robin grant of req_valid: the first set bit strictly after rr_ptr, wrapping.
  - On any grant (a handshake), at the clock edge: load the state, st[0..7]=header, st[8]=nonce[31:0], st[9]=nonce[63:32], st[10..17]=digest, st[18..24]=0.
  - Also at that edge: latch the winner into resp_id, set rr_ptr=winner, set round=0, go to RUN.
- RUN:
  - req_ready=0.
  - Each edge applies ROUNDS_PER_CYCLE chained rounds using round constants round..round+RPC-1, then round+=RPC.
  - When the updated round equals 22: capture st[0..7] into resp_data, set resp_valid=1, go to DONE.
- DONE:
  - resp_valid=1; resp_data and resp_id are held stable while resp_ready=0.
  - resp_valid&resp_ready: resp_valid=0, go to IDLE. There is no new grant in that same cycle.
- Latency:
  - Accept edge to resp_valid high is 22/RPC edges: 22 for RPC=1, 11 for RPC=2, 2 for RPC=11.
  - Minimum request-to-request spacing is 22/RPC+2 cycles.
- Round counter is 5 bits and never exceeds 22. The round constant index is always < 22.
- Arithmetic: rotations are mod 32 (rotate by 0 = identity); all words are 32-bit, and XOR/AND/NOT wrap naturally.
- Starvation bound: a continuously-valid requester is granted within NUM_REQ transactions.
- A requester that drops req_valid before being granted is ignored, with no side effect.
- Reset asserted in any state returns to IDLE next edge with all reset values. Any in-flight result is discarded; no resp_valid pulse.
- resp_ready while not DONE is ignored.

Decomposition:
- Shared package keccak_f800:
  - keccak_state typedef (25x32).
  - keccakf_rotc, keccakf_piln and keccakf_rndc constant arrays.
  - ROTL32 function and the pure keccak_f800_round(state, round) function.
  - KECCAK_ROUNDS=22 localparam.
  - sched FSM enum.
- Sub-module keccak_f800_rr_arb (NUM_REQ): combinational req_valid + rr_ptr -> one-hot grant + encoded index.
- The round datapath is a generate chain of ROUNDS_PER_CYCLE package-function calls, not a separate module.

Test Plan:
- Reset then idle, no requests -> all outputs 0, busy=0, req_ready=0 for 10 cycles.
- RPC=1, requester 0 sends header=0, nonce=0, digest=0 -> req_ready=2'b01 in the same cycle. resp_valid rises exactly 22 edges later with resp_id=0, and resp_data equals the package golden function applied to the same 18 words. Repeat with header words 0x00000001..0x00000008, nonce=0x0123456789ABCDEF, digest=0xFFFFFFFF.
- Both requesters held valid for 4 transactions -> grant order is 0,1,0,1 and resp_id follows; no grant while busy=1.
- Hold resp_ready=0 for 5 cycles in DONE -> resp_valid stays 1, resp_data and resp_id are unchanged, and req_ready stays 0. When resp_ready rises, resp_valid falls the next edge.
- Assert reset 7 cycles into RUN -> next edge: IDLE, resp_valid=0, rr_ptr=1. A subsequent request from requester 1 completes correctly with resp_id=1.
- RPC=2 and RPC=11 builds, same vector as the second scenario -> identical resp_data, with latency 11 and 2 edges respectively.
